// File: rtl/a0_monitor.sv
// a0_monitor: samples the core's a0 result every cycle and queues each new value,
// tagged with a sequence number, in a small FIFO drained over valid/ready.
module a0_monitor #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              a0,
    input  logic                     en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_data,
    output logic [CNT_W-1:0]         out_seq,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0]    FULL_LVL = LW'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [31:0]      last_r;
    logic [CNT_W-1:0] seq_r;
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LW-1:0]    level_r;
    logic             overflow_r;
    logic [CNT_W-1:0] drop_cnt_r;
    logic [31:0]      data_mem_r [DEPTH];
    logic [CNT_W-1:0] seq_mem_r  [DEPTH];

    logic push_req_s;
    logic pop_s;
    logic push_ok_s;
    logic drop_s;
    logic valid_s;

    // Handshake decode; a full FIFO still accepts a push when the head leaves this cycle.
    always_comb begin
        valid_s    = (level_r != {LW{1'b0}});
        push_req_s = en & (a0 != last_r);
        pop_s      = valid_s & out_ready;
        push_ok_s  = push_req_s & ((level_r < FULL_LVL) | pop_s);
        drop_s     = push_req_s & ~push_ok_s;
    end

    // Head presentation, forced to zero when nothing is queued.
    always_comb begin
        out_valid = valid_s;
        level     = level_r;
        overflow  = overflow_r;
        drop_cnt  = drop_cnt_r;
        if (valid_s) begin
            out_data = data_mem_r[rd_ptr_r];
            out_seq  = seq_mem_r[rd_ptr_r];
        end else begin
            out_data = 32'd0;
            out_seq  = {CNT_W{1'b0}};
        end
    end

    // Control state: shadow of a0, sequence counter, pointers, occupancy and loss accounting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_r     <= 32'd0;
            seq_r      <= {CNT_W{1'b0}};
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            level_r    <= {LW{1'b0}};
            overflow_r <= 1'b0;
            drop_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (en) begin
                last_r <= a0;
            end
            if (push_ok_s) begin
                seq_r    <= seq_r + CNT_W'(1);
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
            // Dropped changes never consume a sequence number, only the counter.
            if (drop_s) begin
                overflow_r <= 1'b1;
                if (drop_cnt_r != CNT_MAX) begin
                    drop_cnt_r <= drop_cnt_r + CNT_W'(1);
                end
            end
        end
    end

    // Entry storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            data_mem_r[wr_ptr_r] <= a0;
            seq_mem_r[wr_ptr_r]  <= seq_r;
        end
    end

endmodule

// File: tb/tb_a0_monitor.sv
// Directed bench for a0_monitor: each task drives one scenario and checks
// outputs one time unit after the rising edge against hand-computed values.
module tb_a0_monitor;

    logic        clk;
    logic        rst;
    logic [31:0] a0;
    logic        en;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [7:0]  out_seq;
    logic [3:0]  level;
    logic        overflow;
    logic [7:0]  drop_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    a0_monitor #(.DEPTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .a0(a0), .en(en),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_seq(out_seq), .level(level),
        .overflow(overflow), .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; a0 = 32'd0; en = 1'b0; out_ready = 1'b0;
        #3;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %0h exp 0", out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== 32'd0) $display("FAIL reset_data: got %0h exp 0", out_data); else pass_cnt++;
        total_cnt++; if (out_seq !== 8'd0) $display("FAIL reset_seq: got %0h exp 0", out_seq); else pass_cnt++;
        total_cnt++; if (level !== 4'd0) $display("FAIL reset_level: got %0h exp 0", level); else pass_cnt++;
        total_cnt++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %0h exp 0", overflow); else pass_cnt++;
        total_cnt++; if (drop_cnt !== 8'd0) $display("FAIL reset_drop: got %0h exp 0", drop_cnt); else pass_cnt++;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_zero_hold();
        en = 1'b1; a0 = 32'd0; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total_cnt++; if (out_valid !== 1'b0) $display("FAIL zero_valid: got %0h exp 0", out_valid); else pass_cnt++;
            total_cnt++; if (level !== 4'd0) $display("FAIL zero_level: got %0h exp 0", level); else pass_cnt++;
        end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        a0 = 32'd5; tick();
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL stream_v5: got %0h exp 1", out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== 32'd5) $display("FAIL stream_d5: got %0h exp 5", out_data); else pass_cnt++;
        total_cnt++; if (out_seq !== 8'd0) $display("FAIL stream_s5: got %0h exp 0", out_seq); else pass_cnt++;
        a0 = 32'd5; tick();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL stream_repeat: got %0h exp 0", out_valid); else pass_cnt++;
        a0 = 32'd9; tick();
        total_cnt++; if (out_data !== 32'd9) $display("FAIL stream_d9: got %0h exp 9", out_data); else pass_cnt++;
        total_cnt++; if (out_seq !== 8'd1) $display("FAIL stream_s9: got %0h exp 1", out_seq); else pass_cnt++;
        a0 = 32'd12; tick();
        total_cnt++; if (out_data !== 32'd12) $display("FAIL stream_d12: got %0h exp c", out_data); else pass_cnt++;
        total_cnt++; if (out_seq !== 8'd2) $display("FAIL stream_s12: got %0h exp 2", out_seq); else pass_cnt++;
        total_cnt++; if (level !== 4'd1) $display("FAIL stream_level: got %0h exp 1", level); else pass_cnt++;
        tick();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL stream_empty: got %0h exp 0", out_valid); else pass_cnt++;
        total_cnt++; if (overflow !== 1'b0) $display("FAIL stream_ovf: got %0h exp 0", overflow); else pass_cnt++;
    endtask

    task automatic test_overflow();
        do_reset();
        en = 1'b1; out_ready = 1'b0;
        for (int v = 1; v <= 10; v++) begin
            a0 = 32'(v); tick();
        end
        total_cnt++; if (level !== 4'd8) $display("FAIL ovf_level: got %0h exp 8", level); else pass_cnt++;
        total_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %0h exp 1", overflow); else pass_cnt++;
        total_cnt++; if (drop_cnt !== 8'd2) $display("FAIL ovf_drop: got %0h exp 2", drop_cnt); else pass_cnt++;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total_cnt++; if (out_data !== 32'(i + 1)) $display("FAIL drain_data: got %0h exp %0h", out_data, i + 1); else pass_cnt++;
            total_cnt++; if (out_seq !== 8'(i)) $display("FAIL drain_seq: got %0h exp %0h", out_seq, i); else pass_cnt++;
            tick();
        end
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL drain_empty: got %0h exp 0", out_valid); else pass_cnt++;
        total_cnt++; if (level !== 4'd0) $display("FAIL drain_level: got %0h exp 0", level); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        for (int v = 20; v < 28; v++) begin
            a0 = 32'(v); tick();
        end
        total_cnt++; if (level !== 4'd8) $display("FAIL b2b_full: got %0h exp 8", level); else pass_cnt++;
        a0 = 32'hDEAD_BEEF; out_ready = 1'b1; tick();
        out_ready = 1'b0;
        total_cnt++; if (level !== 4'd8) $display("FAIL b2b_level: got %0h exp 8", level); else pass_cnt++;
        total_cnt++; if (drop_cnt !== 8'd2) $display("FAIL b2b_drop: got %0h exp 2", drop_cnt); else pass_cnt++;
        total_cnt++; if (out_data !== 32'd21) $display("FAIL b2b_head: got %0h exp 15", out_data); else pass_cnt++;
        total_cnt++; if (out_seq !== 8'd9) $display("FAIL b2b_headseq: got %0h exp 9", out_seq); else pass_cnt++;
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        total_cnt++; if (out_data !== 32'hDEAD_BEEF) $display("FAIL b2b_tail: got %0h exp deadbeef", out_data); else pass_cnt++;
        total_cnt++; if (out_seq !== 8'd16) $display("FAIL b2b_tailseq: got %0h exp 10", out_seq); else pass_cnt++;
        total_cnt++; if (level !== 4'd1) $display("FAIL b2b_taillvl: got %0h exp 1", level); else pass_cnt++;
        tick();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL b2b_empty: got %0h exp 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_enable_wrap();
        do_reset();
        en = 1'b0; out_ready = 1'b0;
        a0 = 32'd3; tick();
        a0 = 32'd4; tick();
        a0 = 32'd3; tick();
        total_cnt++; if (level !== 4'd0) $display("FAIL en_off_level: got %0h exp 0", level); else pass_cnt++;
        en = 1'b1; tick();
        total_cnt++; if (out_data !== 32'd3) $display("FAIL en_on_data: got %0h exp 3", out_data); else pass_cnt++;
        total_cnt++; if (out_seq !== 8'd0) $display("FAIL en_on_seq: got %0h exp 0", out_seq); else pass_cnt++;
        out_ready = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            a0 = 32'(100 + k); tick();
            total_cnt++; if (out_data !== 32'(100 + k)) $display("FAIL wrap_data: got %0h exp %0h", out_data, 100 + k); else pass_cnt++;
            total_cnt++; if (out_seq !== 8'(k % 256)) $display("FAIL wrap_seq: got %0h exp %0h", out_seq, k % 256); else pass_cnt++;
        end
        total_cnt++; if (level !== 4'd1) $display("FAIL wrap_level: got %0h exp 1", level); else pass_cnt++;
        total_cnt++; if (drop_cnt !== 8'd0) $display("FAIL wrap_drop: got %0h exp 0", drop_cnt); else pass_cnt++;
    endtask

    task automatic test_reset_midstream();
        do_reset();
        en = 1'b1; out_ready = 1'b0;
        for (int v = 1; v <= 9; v++) begin
            a0 = 32'(v); tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        out_ready = 1'b0;
        total_cnt++; if (level !== 4'd4) $display("FAIL mid_level: got %0h exp 4", level); else pass_cnt++;
        total_cnt++; if (overflow !== 1'b1) $display("FAIL mid_ovf: got %0h exp 1", overflow); else pass_cnt++;
        #1 rst = 1'b1;
        #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL mid_rst_valid: got %0h exp 0", out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== 32'd0) $display("FAIL mid_rst_data: got %0h exp 0", out_data); else pass_cnt++;
        total_cnt++; if (out_seq !== 8'd0) $display("FAIL mid_rst_seq: got %0h exp 0", out_seq); else pass_cnt++;
        total_cnt++; if (level !== 4'd0) $display("FAIL mid_rst_level: got %0h exp 0", level); else pass_cnt++;
        total_cnt++; if (overflow !== 1'b0) $display("FAIL mid_rst_ovf: got %0h exp 0", overflow); else pass_cnt++;
        total_cnt++; if (drop_cnt !== 8'd0) $display("FAIL mid_rst_drop: got %0h exp 0", drop_cnt); else pass_cnt++;
        a0 = 32'd7;
        tick();
        rst = 1'b0;
        tick();
        total_cnt++; if (out_data !== 32'd7) $display("FAIL post_rst_data: got %0h exp 7", out_data); else pass_cnt++;
        total_cnt++; if (out_seq !== 8'd0) $display("FAIL post_rst_seq: got %0h exp 0", out_seq); else pass_cnt++;
        total_cnt++; if (level !== 4'd1) $display("FAIL post_rst_level: got %0h exp 1", level); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_zero_hold();
        test_stream();
        test_overflow();
        test_back_to_back();
        test_enable_wrap();
        test_reset_midstream();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
